pipeline_ctrl: RTL and testbench

- Central sequencing and hazard controller for the 5-stage CPU core pipeline.
- Owns the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register enables and the IF/ID and ID/EX flushes.
- Runs a debug execution FSM (idle / continuous run / single step / halted) driven by the debug unit.
- Inserts load-use bubbles and branch/jump flushes, and counts executed cycles.

---
 rtl/pipeline_ctrl.sv | 73 +++++++
 tb/tb_pipeline_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: debug run/step/halt FSM, load-use and branch hazard enables/flushes, saturating cycle counter.
// Optional PIPELINE_CTRL_STALL_CNT_EN adds a saturating load-use stall counter on o_stall_cnt.
module pipeline_ctrl #(
  parameter int NB_CYCLES = 32,
  parameter int NB_REG_ADDR = 5
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_run,
  input  logic                   i_step,
  input  logic                   i_halt_req,
  input  logic                   i_halt_instr,
  input  logic                   i_branch_taken,
  input  logic                   i_id_ex_memRead,
  input  logic [NB_REG_ADDR-1:0] i_id_ex_rd_addr,
  input  logic [NB_REG_ADDR-1:0] i_if_id_rs1_addr,
  input  logic [NB_REG_ADDR-1:0] i_if_id_rs2_addr,
  input  logic                   i_if_id_rs1_used,
  input  logic                   i_if_id_rs2_used,
  output logic                   o_pc_en,
  output logic                   o_if_id_en,
  output logic                   o_if_id_flush,
  output logic                   o_id_ex_en,
  output logic                   o_id_ex_flush,
  output logic                   o_ex_mem_en,
  output logic                   o_mem_wb_en,
  output logic [1:0]             o_state,
  output logic                   o_halted,
  output logic [NB_CYCLES-1:0]   o_cycle_cnt
`ifdef PIPELINE_CTRL_STALL_CNT_EN
  ,
  output logic [NB_CYCLES-1:0]   o_stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;
  state_t state;
  logic advance, load_use, stall;
  assign advance  = state == RUN || state == STEP;
  assign load_use = i_id_ex_memRead && i_id_ex_rd_addr != '0 &&
                    ((i_if_id_rs1_used && i_id_ex_rd_addr == i_if_id_rs1_addr) ||
                     (i_if_id_rs2_used && i_id_ex_rd_addr == i_if_id_rs2_addr));
  // a taken branch squashes the dependent instruction, so it overrides the load-use stall
  assign stall         = advance && load_use && !i_branch_taken;
  assign o_pc_en       = advance && !stall;
  assign o_if_id_en    = advance && !stall;
  assign o_if_id_flush = advance && i_branch_taken;
  assign o_id_ex_en    = advance;
  assign o_id_ex_flush = advance && (i_branch_taken || load_use);
  assign o_ex_mem_en   = advance;
  assign o_mem_wb_en   = advance;
  assign o_state       = state;
  assign o_halted      = state == HALTED;
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state       <= IDLE;
      o_cycle_cnt <= '0;
    end else begin
      case (state)
        IDLE:    state <= i_run ? RUN : i_step ? STEP : IDLE;
        RUN:     state <= i_halt_instr ? HALTED : i_halt_req ? IDLE : RUN;
        STEP:    state <= i_halt_instr ? HALTED : IDLE;
        default: state <= HALTED;
      endcase
      if (advance && !(&o_cycle_cnt)) o_cycle_cnt <= o_cycle_cnt + NB_CYCLES'(1);
    end
  end
`ifdef PIPELINE_CTRL_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (i_rst) o_stall_cnt <= '0;
    else if (stall && !(&o_stall_cnt)) o_stall_cnt <= o_stall_cnt + NB_CYCLES'(1);
  end
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vector table plus random stimulus against a behavioural model;
// a second 4-bit-counter instance exercises counter saturation.
module tb_pipeline_ctrl;
  localparam logic [6:0] C_RST = 7'b1000000, C_RUN = 7'b0100000, C_STEP = 7'b0010000,
                         C_HR = 7'b0001000, C_HI = 7'b0000100, C_BR = 7'b0000010, C_MR = 7'b0000001;
  localparam logic [6:0] E_OFF = 7'b0000000, E_NH = 7'b1101011, E_LU = 7'b0001111, E_BR = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, run, step, hr, hi, br, mr, u1, u2;
  logic [4:0] rd, rs1, rs2;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, halted;
  logic [1:0] st;
  logic [31:0] cnt;
  logic s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush, s_ex_mem_en, s_mem_wb_en, s_halted;
  logic [1:0] s_st;
  logic [3:0] s_cnt;
`ifdef PIPELINE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [3:0] s_stall_cnt;
`endif

  pipeline_ctrl dut (
    .clk(clk), .i_rst(rst), .i_run(run), .i_step(step), .i_halt_req(hr), .i_halt_instr(hi),
    .i_branch_taken(br), .i_id_ex_memRead(mr), .i_id_ex_rd_addr(rd), .i_if_id_rs1_addr(rs1),
    .i_if_id_rs2_addr(rs2), .i_if_id_rs1_used(u1), .i_if_id_rs2_used(u2),
    .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_if_id_flush(if_id_flush), .o_id_ex_en(id_ex_en),
    .o_id_ex_flush(id_ex_flush), .o_ex_mem_en(ex_mem_en), .o_mem_wb_en(mem_wb_en),
    .o_state(st), .o_halted(halted), .o_cycle_cnt(cnt)
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    , .o_stall_cnt(stall_cnt)
`endif
  );

  pipeline_ctrl #(.NB_CYCLES(4)) dut_s (
    .clk(clk), .i_rst(rst), .i_run(run), .i_step(step), .i_halt_req(hr), .i_halt_instr(hi),
    .i_branch_taken(br), .i_id_ex_memRead(mr), .i_id_ex_rd_addr(rd), .i_if_id_rs1_addr(rs1),
    .i_if_id_rs2_addr(rs2), .i_if_id_rs1_used(u1), .i_if_id_rs2_used(u2),
    .o_pc_en(s_pc_en), .o_if_id_en(s_if_id_en), .o_if_id_flush(s_if_id_flush), .o_id_ex_en(s_id_ex_en),
    .o_id_ex_flush(s_id_ex_flush), .o_ex_mem_en(s_ex_mem_en), .o_mem_wb_en(s_mem_wb_en),
    .o_state(s_st), .o_halted(s_halted), .o_cycle_cnt(s_cnt)
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    , .o_stall_cnt(s_stall_cnt)
`endif
  );

  int checks = 0, errors = 0;
  int m_st;
  longint m_cyc, m_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_adv();
    return m_st == 1 || m_st == 2;
  endfunction

  function automatic bit m_lu();
    if (!mr || rd == 0) return 0;
    return (u1 && rd == rs1) || (u2 && rd == rs2);
  endfunction

  function automatic logic [6:0] m_en();
    if (!m_adv()) return E_OFF;
    if (br) return E_BR;
    if (m_lu()) return E_LU;
    return E_NH;
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return v > mx ? mx : v;
  endfunction

  // check all outputs against the model, then let the clock edge happen and step the model
  task automatic tick();
    #1;
    chk("state", st, m_st);
    chk("halted", halted, m_st == 3);
    chk("enables", {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}, m_en());
    chk("cycle_cnt", cnt, m_cyc);
    chk("cycle_cnt_sat4", s_cnt, sat(m_cyc, 15));
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("stall_cnt_sat4", s_stall_cnt, sat(m_stall, 15));
`endif
    @(posedge clk);
    if (rst) begin
      m_st = 0; m_cyc = 0; m_stall = 0;
    end else begin
      if (m_adv()) m_cyc++;
      if (m_adv() && m_lu() && !br) m_stall++;
      case (m_st)
        0: m_st = run ? 1 : step ? 2 : 0;
        1: m_st = hi ? 3 : hr ? 0 : 1;
        2: m_st = hi ? 3 : 0;
        default: m_st = 3;
      endcase
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [6:0] cmd;
    logic [4:0] rd, rs1, rs2;
    logic [1:0] use_;
    logic [1:0] st;
    logic [6:0] en;
    int cnt;
  } vec_t;
  vec_t tbl[$];

  initial begin
    {rst, run, step, hr, hi, br, mr, u1, u2} = '0;
    {rd, rs1, rs2} = '0;
    rst = 1'b1;
    @(posedge clk);
    m_st = 0; m_cyc = 0; m_stall = 0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) tbl.push_back('{0, 0, 0, 0, 0, 0, E_OFF, 0});
    tbl.push_back('{C_RUN, 0, 0, 0, 0, 0, E_OFF, 0});
    for (int i = 0; i < 10; i++) tbl.push_back('{0, 0, 0, 0, 0, 1, E_NH, i});
    tbl.push_back('{C_HR, 0, 0, 0, 0, 1, E_NH, 10});
    tbl.push_back('{0, 0, 0, 0, 0, 0, E_OFF, 11});
    tbl.push_back('{C_HI | C_HR, 0, 0, 0, 0, 0, E_OFF, 11});
    for (int k = 0; k < 3; k++) begin
      tbl.push_back('{C_STEP, 0, 0, 0, 0, 0, E_OFF, 11 + k});
      tbl.push_back('{0, 0, 0, 0, 0, 2, E_NH, 11 + k});
      tbl.push_back('{0, 0, 0, 0, 0, 0, E_OFF, 12 + k});
    end
    tbl.push_back('{C_RUN | C_STEP, 0, 0, 0, 0, 0, E_OFF, 14});
    tbl.push_back('{C_MR, 5, 5, 0, 2'b10, 1, E_LU, 14});
    tbl.push_back('{C_MR, 0, 0, 0, 2'b11, 1, E_NH, 15});
    tbl.push_back('{C_MR | C_BR, 5, 5, 0, 2'b10, 1, E_BR, 16});
    tbl.push_back('{C_MR, 7, 1, 7, 2'b01, 1, E_LU, 17});
    tbl.push_back('{C_MR, 7, 1, 7, 2'b10, 1, E_NH, 18});
    tbl.push_back('{C_HI, 0, 0, 0, 0, 1, E_NH, 19});
    tbl.push_back('{C_RUN | C_STEP, 0, 0, 0, 0, 3, E_OFF, 20});
    tbl.push_back('{C_HR | C_HI, 0, 0, 0, 0, 3, E_OFF, 20});
    tbl.push_back('{C_RST | C_RUN, 0, 0, 0, 0, 3, E_OFF, 20});
    tbl.push_back('{0, 0, 0, 0, 0, 0, E_OFF, 0});

    foreach (tbl[i]) begin
      {rst, run, step, hr, hi, br, mr} = tbl[i].cmd;
      rd = tbl[i].rd; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
      {u1, u2} = tbl[i].use_;
      #1;
      chk($sformatf("tbl%0d_state", i), st, tbl[i].st);
      chk($sformatf("tbl%0d_en", i),
          {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}, tbl[i].en);
      chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].cnt);
      tick();
    end

    // STEP that meets a halt instruction goes straight to HALTED
    {rst, run, step, hr, hi, br, mr, u1, u2} = '0;
    step = 1'b1; tick();
    step = 1'b0; hi = 1'b1; tick();
    hi = 1'b0; #1 chk("step_to_halted", st, 2'd3);
    tick();
    rst = 1'b1; tick();
    rst = 1'b0; #1 chk("reset_from_halted", st, 2'd0);

    for (int i = 0; i < 4000; i++) begin
      rst  = $urandom_range(0, 149) == 0;
      run  = $urandom_range(0, 7) == 0;
      step = $urandom_range(0, 3) == 0;
      hr   = $urandom_range(0, 9) == 0;
      hi   = $urandom_range(0, 59) == 0;
      br   = $urandom_range(0, 4) == 0;
      mr   = $urandom_range(0, 1) == 0;
      rd   = 5'($urandom_range(0, 3));
      rs1  = 5'($urandom_range(0, 3));
      rs2  = 5'($urandom_range(0, 3));
      u1   = 1'($urandom_range(0, 1));
      u2   = 1'($urandom_range(0, 1));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
